// File: rtl/buf_share_arb_pkg.sv
// Shared definitions for the buffer-sharing arbiter: FSM encoding, default
// sizing and a one-hot to index helper.
package buf_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int DEF_N        = 4;
   localparam int DEF_MAX_HOLD = 16;

   // Supports up to 8 requesters; callers zero-extend narrower vectors.
   function automatic logic [2:0] oh2idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/buf_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping at N, returned as a one-hot vector plus a valid flag.
module rr_pick
   import buf_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_pick,
   output logic          o_valid
);

   localparam int KW = IW + 1;

   logic [KW-1:0] w_idx;

   // One extra bit on the index so ptr+i can be wrapped for non power-of-2 N.
   always_comb begin
      o_pick  = '0;
      o_valid = 1'b0;
      w_idx   = '0;
      for (int i = 0; i < N; i++) begin
         w_idx = {1'b0, i_ptr} + KW'(i);
         if (w_idx >= KW'(N)) w_idx = w_idx - KW'(N);
         if (!o_valid && i_req[w_idx[IW-1:0]]) begin
            o_pick[w_idx[IW-1:0]] = 1'b1;
            o_valid               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/buf_share_arb.sv
// Round-robin controller that lends one shared buffer cell to N requesters,
// steering the owner's data bit to the buffer and bounding hold time.
module buf_share_arb
   import buf_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic [N-1:0] done,
   input  logic [N-1:0] a_in,
   output logic [N-1:0] gnt,
   output logic         buf_a,
   output logic         buf_en,
   output logic         timeout,
   output state_t       dbg_state
);

   // Handshake: req is a level held while a requester wants the buffer; gnt
   // rises one cycle after req is seen in IDLE and stays until the owner
   // drops req, pulses done, or is forced off at MAX_HOLD cycles. Only the
   // owner's req/done bits are looked at while a grant is active.

   localparam int IW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD);

   state_t        r_state, w_state_nxt;
   logic [N-1:0]  r_gnt, w_gnt_nxt;
   logic          r_buf_a, w_buf_a_nxt;
   logic          r_buf_en, w_buf_en_nxt;
   logic          r_timeout, w_timeout_nxt;
   logic [IW-1:0] r_rr_ptr, w_rr_ptr_nxt;
   logic [IW-1:0] r_owner, w_owner_nxt;
   logic [HW-1:0] r_hold_cnt, w_hold_cnt_nxt;

   logic [N-1:0]  w_pick;
   logic          w_pick_valid;
   logic [IW-1:0] w_pick_idx;
   logic          w_own_done;
   logic          w_own_req;
   logic          w_hold_max;
   logic          w_release;

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_rr_pick (
      .i_req   (req),
      .i_ptr   (r_rr_ptr),
      .o_pick  (w_pick),
      .o_valid (w_pick_valid)
   );

   assign w_pick_idx = IW'(oh2idx(8'(w_pick)));
   assign w_own_done = done[r_owner];
   assign w_own_req  = req[r_owner];
   assign w_hold_max = (r_hold_cnt == HW'(MAX_HOLD - 1));
   assign w_release  = w_own_done || !w_own_req || w_hold_max;

   always_comb begin
      w_state_nxt    = r_state;
      w_gnt_nxt      = r_gnt;
      w_buf_a_nxt    = 1'b0;
      w_buf_en_nxt   = 1'b0;
      w_timeout_nxt  = 1'b0;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_owner_nxt    = r_owner;
      w_hold_cnt_nxt = r_hold_cnt;
      case (r_state)
         IDLE: begin
            w_gnt_nxt = '0;
            if (w_pick_valid) begin
               w_state_nxt    = OWN;
               w_gnt_nxt      = w_pick;
               w_owner_nxt    = w_pick_idx;
               w_hold_cnt_nxt = '0;
               w_buf_en_nxt   = 1'b1;
               w_buf_a_nxt    = a_in[w_pick_idx];
            end
         end
         OWN: begin
            if (w_release) begin
               w_state_nxt    = GAP;
               w_gnt_nxt      = '0;
               w_hold_cnt_nxt = '0;
               w_rr_ptr_nxt   = (r_owner == IW'(N - 1)) ? '0 : r_owner + 1'b1;
               // A cooperative release in the same cycle wins over the limit.
               w_timeout_nxt  = w_hold_max && !w_own_done && w_own_req;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + 1'b1;
               w_buf_en_nxt   = 1'b1;
               w_buf_a_nxt    = a_in[r_owner];
            end
         end
         GAP: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_buf_a    <= 1'b0;
         r_buf_en   <= 1'b0;
         r_timeout  <= 1'b0;
         r_rr_ptr   <= '0;
         r_owner    <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_gnt      <= w_gnt_nxt;
         r_buf_a    <= w_buf_a_nxt;
         r_buf_en   <= w_buf_en_nxt;
         r_timeout  <= w_timeout_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_owner    <= w_owner_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
      end
   end

   assign gnt       = r_gnt;
   assign buf_a     = r_buf_a;
   assign buf_en    = r_buf_en;
   assign timeout   = r_timeout;
   assign dbg_state = r_state;

endmodule

// File: doc/buf_share_arb.md
Name: buf_share_arb

Overview:
- Round-robin arbiter/controller sharing one `buffer` instance between N requesters.
- Grants exclusive use of the buffer input to one requester at a time.
- Routes that requester's data bit to the buffer's `a` input and drives a buffer-enable.
- Bounds hold time so no requester starves the others.
- Sits between requester logic and the single `buffer` datapath cell.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the buffer (>=2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request per requester; level, held while wanting the buffer.
- done  input  N  release pulse per requester; only the current owner's bit is honoured.
- a_in  input  N  data bit per requester to be driven through the buffer.
- gnt  output  N  one-hot grant, registered; all-zero when nobody owns the buffer.
- buf_a  output  1  registered data to the buffer `a` input.
- buf_en  output  1  high while an owner's data is valid on buf_a.
- timeout  output  1  one-cycle pulse when an owner is force-released at MAX_HOLD.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high. All state updates on rising edge of clk.
- Reset values: gnt=0, buf_a=0, buf_en=0, timeout=0, state=IDLE, rr_ptr=0, hold_cnt=0.
- States: IDLE, OWN, GAP.
- IDLE:
  - If any req bit is set, select the first set bit searching from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., N-1, 0, ...).
  - Next cycle: gnt=onehot(sel), state=OWN, hold_cnt=0.
  - Grant latency: req high in cycle t -> gnt high in cycle t+1.
  - If no req, remain in IDLE with all outputs 0.
- OWN:
  - buf_a <= a_in[owner] and buf_en <= 1 every cycle. buf_a lags a_in by one cycle.
  - hold_cnt increments by 1 per cycle.
  - Release when done[owner]=1 OR req[owner]=0 OR hold_cnt==MAX_HOLD-1.
  - On release: next cycle gnt=0, buf_en=0, buf_a=0, state=GAP, rr_ptr=(owner+1) mod N.
  - timeout pulses for exactly that cycle only if release was due to hold_cnt, with done[owner]=0 and req[owner]=1.
  - done/req from non-owners are ignored while in OWN.
- GAP:
  - Exactly one turnaround cycle with buffer disabled, then IDLE.
  - Arbitration resumes in IDLE, so back-to-back owners are separated by 2 idle cycles of gnt=0.
- Simultaneous events: done and timeout in the same cycle count as a normal release, so timeout=0.
- Fairness: the owner just released has lowest priority in the next arbitration.
- Wrap-around: rr_ptr wraps at N. hold_cnt width is $clog2(MAX_HOLD) and never exceeds MAX_HOLD-1.
- Reset mid-OWN: next cycle all outputs 0, state IDLE, rr_ptr=0. No timeout pulse.
- Invariants:
  - gnt is always one-hot or zero.
  - buf_en == |gnt.
  - buf_a == 0 whenever buf_en==0.

Decomposition:
- Shared package buf_pkg holds:
  - State encoding: IDLE=2'd0, OWN=2'd1, GAP=2'd2.
  - Default constants for N and MAX_HOLD.
- One sub-module: rr_pick. It is combinational, takes (req, rr_ptr) and returns a one-hot pick plus a valid flag. It is instantiated once.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 for 10 cycles -> gnt=0, buf_en=0, buf_a=0 throughout.
- Single requester: req=4'b0100 at t=5, a_in[2] toggles every 100ns -> gnt=4'b0100 at t=6. buf_a follows a_in[2] delayed 1 cycle. done[2] at t=10 -> gnt=0 at t=11, rr_ptr=3.
- Round-robin: req=4'b1111 held, owners pulse done after 3 cycles -> grant order 0,1,2,3,0. Each grant is separated by 2 gnt=0 cycles.
- Timeout: req=4'b0011 held, no done, MAX_HOLD=16 -> owner 0 released after 16 OWN cycles with timeout=1 for one cycle, then gnt=4'b0010.
- Ignored foreign done: owner 1 granted, done=4'b0001 pulse -> gnt stays 4'b0010 and timeout=0.
- Reset mid-operation: rst asserted while gnt=4'b1000 -> next cycle gnt=0, buf_en=0, timeout=0. After release of rst with req=4'b1001 -> gnt=4'b0001, since rr_ptr was reset to 0.
